mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, max cycles mem_req_o may wait for mem_ready_i before error_o sets.
REQ-002 clk_i  input  1  clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 if_req_i  input  1  fetch stage requests instruction word.
REQ-005 if_addr_i  input  32  fetch byte address.
REQ-006 if_flush_i  input  1  branch taken; discard pending/returning fetch.
REQ-007 if_rdata_o  output  32  fetched instruction, valid when if_valid_o=1.
REQ-008 if_valid_o  output  1  one-cycle fetch-complete pulse.
REQ-009 if_stall_o  output  1  fetch not yet served; hold PC and IF/ID.
REQ-010 dm_read_i  input  1  MEM stage load.
REQ-011 dm_write_i  input  1  MEM stage store.
REQ-012 dm_addr_i  input  32  data byte address.
REQ-013 dm_wdata_i  input  32  store data.
REQ-014 dm_rdata_o  output  32  load data, valid when dm_valid_o=1.
REQ-015 dm_valid_o  output  1  one-cycle data-complete pulse.
REQ-016 dm_stall_o  output  1  data access not yet served; freeze whole pipeline.
REQ-017 mem_req_o  output  1  request to shared single-port memory.
REQ-018 mem_we_o  output  1  1=write, 0=read.
REQ-019 mem_addr_o  output  32  memory address.
REQ-020 mem_wdata_o  output  32  memory write data.
REQ-021 mem_ready_i  input  1  memory completes current request this cycle.
REQ-022 mem_rdata_i  input  32  memory read data, valid with mem_ready_i.
REQ-023 error_o  output  1  sticky timeout flag.

Function
REQ-024 FSM states SHALL be IDLE, FETCH, DATA; only IDLE arbitrates.
REQ-025 In IDLE, an eligible data request (dm_read_i|dm_write_i) SHALL win over an eligible fetch; next state DATA, else FETCH, else IDLE.
REQ-026 A requester SHALL be ineligible in any cycle its valid output is 1 (request already served).
REQ-027 On grant, mem_addr_o/mem_we_o/mem_wdata_o SHALL be registered and held constant while mem_req_o=1; fetch drives mem_we_o=0, mem_wdata_o=0.
REQ-028 mem_req_o SHALL be 1 exactly while state is FETCH or DATA.
REQ-029 mem_ready_i in DATA SHALL: pulse dm_valid_o next cycle, register dm_rdata_o=mem_rdata_i for loads (0 for stores), return IDLE.
REQ-030 mem_ready_i in FETCH SHALL: pulse if_valid_o next cycle with if_rdata_o=mem_rdata_i, return IDLE, unless dropped (REQ-033).
REQ-031 Minimum latency: request in IDLE at cycle t, mem_ready_i at t+1, valid pulse at t+2.
REQ-032 dm_stall_o = (dm_read_i|dm_write_i) & ~dm_valid_o; if_stall_o = if_req_i & ~if_valid_o & ~if_flush_i.
REQ-033 if_flush_i during FETCH SHALL set a drop flag; the memory read still completes, if_valid_o stays 0, flag clears on return to IDLE.
REQ-034 if_flush_i coincident with would-be if_valid_o SHALL suppress that pulse.
REQ-035 mem_ready_i in IDLE SHALL be ignored.
REQ-036 A wait counter SHALL count cycles with mem_req_o=1 and mem_ready_i=0, clear on grant; reaching TIMEOUT sets error_o until reset; FSM keeps waiting.
REQ-037 Simultaneous store and load (both dm inputs 1) SHALL be treated as write.

Reset
REQ-038 rst_i=1 at an edge SHALL force IDLE, clear drop flag, wait counter, error_o, both valid pulses, data outputs and mem_* outputs to 0, including mid-transaction.
REQ-039 Combinational stall outputs SHALL follow REQ-032 during reset.

Verification
REQ-040 Fetch only: if_req_i=1, addr 0x0000_0040, mem_ready_i one cycle after mem_req_o with 0x2002_0005 -> if_valid_o at t+2, if_rdata_o=0x2002_0005, if_stall_o=1 at t, t+1.
REQ-041 Conflict: if_req_i=1 and dm_read_i=1 addr 0x100 same cycle -> DATA first, dm_valid_o, then FETCH granted; fetch valid no earlier than 2 cycles after dm_valid_o.
REQ-042 Store: dm_write_i=1 addr 0x8, wdata 0xDEAD_BEEF -> mem_we_o=1, mem_wdata_o=0xDEAD_BEEF held until mem_ready_i; dm_rdata_o=0.
REQ-043 Flush: if_flush_i pulse during FETCH with 3-cycle memory latency -> no if_valid_o; next fetch to new address served normally.
REQ-044 Timeout: TIMEOUT=4, mem_ready_i held 0 -> error_o=1 after 4 wait cycles, stays 1 after late mem_ready_i until rst_i.
REQ-045 Reset mid-DATA: rst_i=1 while mem_req_o=1 -> next edge mem_req_o=0, state IDLE, no dm_valid_o.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port memory between instruction fetch and data access.
// Data wins over fetch; a wait counter flags a sticky timeout error.
module mem_port_arbiter #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   input  logic        if_flush_i,
   output logic [31:0] if_rdata_o,
   output logic        if_valid_o,
   output logic        if_stall_o,
   input  logic        dm_read_i,
   input  logic        dm_write_i,
   input  logic [31:0] dm_addr_i,
   input  logic [31:0] dm_wdata_i,
   output logic [31:0] dm_rdata_o,
   output logic        dm_valid_o,
   output logic        dm_stall_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_ready_i,
   input  logic [31:0] mem_rdata_i,
   output logic        error_o
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

   state_t          state, state_nxt;
   logic            grant_data, grant_fetch;
   logic            data_elig, fetch_elig;
   logic            if_valid_q;
   logic            drop;
   logic [CW-1:0]   wait_cnt;
   logic            waiting;

   // A flush arriving in the pulse cycle itself still suppresses the fetch result.
   assign if_valid_o = if_valid_q & ~if_flush_i;
   assign mem_req_o  = (state != IDLE);
   assign waiting    = mem_req_o & ~mem_ready_i;

   assign data_elig  = (dm_read_i | dm_write_i) & ~dm_valid_o;
   assign fetch_elig = if_req_i & ~if_valid_o;

   assign dm_stall_o = (dm_read_i | dm_write_i) & ~dm_valid_o;
   assign if_stall_o = if_req_i & ~if_valid_o & ~if_flush_i;

   always_comb begin
      state_nxt   = state;
      grant_data  = 1'b0;
      grant_fetch = 1'b0;
      case (state)
         IDLE: begin
            if (data_elig) begin
               state_nxt  = DATA;
               grant_data = 1'b1;
            end else if (fetch_elig) begin
               state_nxt   = FETCH;
               grant_fetch = 1'b1;
            end
         end
         FETCH:   if (mem_ready_i) state_nxt = IDLE;
         DATA:    if (mem_ready_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= IDLE;
         drop        <= 1'b0;
         wait_cnt    <= '0;
         error_o     <= 1'b0;
         if_valid_q  <= 1'b0;
         if_rdata_o  <= '0;
         dm_valid_o  <= 1'b0;
         dm_rdata_o  <= '0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
      end else begin
         state <= state_nxt;

         dm_valid_o <= (state == DATA) & mem_ready_i;
         if ((state == DATA) && mem_ready_i)
            dm_rdata_o <= mem_we_o ? 32'd0 : mem_rdata_i;

         if_valid_q <= (state == FETCH) & mem_ready_i & ~drop & ~if_flush_i;
         if ((state == FETCH) && mem_ready_i)
            if_rdata_o <= mem_rdata_i;

         // Drop flag lives only for the remainder of the current fetch.
         drop <= (state == FETCH) & ~mem_ready_i & (drop | if_flush_i);

         if (grant_data) begin
            mem_we_o    <= dm_write_i;
            mem_addr_o  <= dm_addr_i;
            mem_wdata_o <= dm_write_i ? dm_wdata_i : 32'd0;
         end else if (grant_fetch) begin
            mem_we_o    <= 1'b0;
            mem_addr_o  <= if_addr_i;
            mem_wdata_o <= 32'd0;
         end

         if (grant_data || grant_fetch) begin
            wait_cnt <= '0;
         end else if (waiting) begin
            if (int'(wait_cnt) < TIMEOUT) wait_cnt <= wait_cnt + CW'(1);
            if (int'(wait_cnt) >= TIMEOUT - 1) error_o <= 1'b1;
         end
      end
   end

endmodule
